// File: rtl/jump_ctrl.sv
// rtl/jump_ctrl.sv - jump command initiator for the character block
//
// Turns debounced left/right button presses into one-cycle jump commands,
// then waits for the character's landed acknowledgement before accepting
// the next press. Tracks the score and latches game over after a fall or
// a landing timeout.
//
// Ports:
//   clk           in   game clock (40 MHz)
//   rst_n         in   synchronous active-low reset
//   module_en     in   game active; low clears everything like reset
//   btn_left      in   debounced left button level
//   btn_right     in   debounced right button level
//   block_side    in   side of next block (0 = left, 1 = right)
//   block_valid   in   block_side is meaningful
//   landed        in   one-cycle pulse: jump or fall complete
//   jump_left     out  one-cycle command pulse
//   jump_right    out  one-cycle command pulse
//   jump_fail     out  one-cycle command pulse
//   block_advance out  one-cycle pulse requesting the next block
//   score         out  successful jumps, saturating at SCORE_MAX
//   game_over     out  level, high from game end until clear
//   timeout_err   out  level, high if game over came from the timeout

module jump_ctrl #(
    parameter logic [23:0] LAND_TIMEOUT = 24'd16_000_000,
    parameter logic [9:0]  SCORE_MAX    = 10'd999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       module_en,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       block_side,
    input  logic       block_valid,
    input  logic       landed,
    output logic       jump_left,
    output logic       jump_right,
    output logic       jump_fail,
    output logic       block_advance,
    output logic [9:0] score,
    output logic       game_over,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_WAIT  = 2'd1,
        S_FALL  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        prev_l_q, prev_r_q;

    logic        jump_left_q, jump_left_d;
    logic        jump_right_q, jump_right_d;
    logic        jump_fail_q, jump_fail_d;
    logic        block_advance_q, block_advance_d;
    logic [9:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic        timeout_err_q, timeout_err_d;

    logic        rise_l, rise_r, press, timed_out;

    assign rise_l = btn_left & ~prev_l_q;
    assign rise_r = btn_right & ~prev_r_q;
    // Exactly one rising edge counts as a press; simultaneous rises are dropped.
    assign press  = rise_l ^ rise_r;
    // Timer counts from 0 after the command, so LAND_TIMEOUT-1 is the last
    // cycle that still waits for landed.
    assign timed_out = (timer_q >= (LAND_TIMEOUT - 24'd1));

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        jump_left_d     = 1'b0;
        jump_right_d    = 1'b0;
        jump_fail_d     = 1'b0;
        block_advance_d = 1'b0;
        score_d         = score_q;
        game_over_d     = game_over_q;
        timeout_err_d   = timeout_err_q;

        case (state_q)
            S_READY: begin
                if (press) begin
                    timer_d = 24'd0;
                    // rise_r doubles as the pressed direction (1 = right).
                    if (block_valid && (rise_r == block_side)) begin
                        jump_left_d  = rise_l;
                        jump_right_d = rise_r;
                        state_d      = S_WAIT;
                    end else begin
                        jump_fail_d = 1'b1;
                        state_d     = S_FALL;
                    end
                end
            end

            S_WAIT: begin
                // landed takes priority over a coincident timeout.
                if (landed) begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 10'd1;
                    end
                    block_advance_d = 1'b1;
                    state_d         = S_READY;
                end else if (timed_out) begin
                    game_over_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = S_OVER;
                end else if (timer_q != 24'hFF_FFFF) begin
                    timer_d = timer_q + 24'd1;
                end
            end

            S_FALL: begin
                if (landed) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else if (timed_out) begin
                    game_over_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = S_OVER;
                end else if (timer_q != 24'hFF_FFFF) begin
                    timer_d = timer_q + 24'd1;
                end
            end

            default: begin
                state_d = S_OVER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !module_en) begin
            state_q         <= S_READY;
            timer_q         <= 24'd0;
            // History starts high so a button held through clear needs a release.
            prev_l_q        <= 1'b1;
            prev_r_q        <= 1'b1;
            jump_left_q     <= 1'b0;
            jump_right_q    <= 1'b0;
            jump_fail_q     <= 1'b0;
            block_advance_q <= 1'b0;
            score_q         <= 10'd0;
            game_over_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            prev_l_q        <= btn_left;
            prev_r_q        <= btn_right;
            jump_left_q     <= jump_left_d;
            jump_right_q    <= jump_right_d;
            jump_fail_q     <= jump_fail_d;
            block_advance_q <= block_advance_d;
            score_q         <= score_d;
            game_over_q     <= game_over_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign jump_left     = jump_left_q;
    assign jump_right    = jump_right_q;
    assign jump_fail     = jump_fail_q;
    assign block_advance = block_advance_q;
    assign score         = score_q;
    assign game_over     = game_over_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// tb/tb_jump_ctrl.sv - self-checking bench for jump_ctrl
module tb_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, module_en, btn_left, btn_right, block_side, block_valid, landed;
    logic       jump_left, jump_right, jump_fail, block_advance, game_over, timeout_err;
    logic [9:0] score;

    int checks = 0;
    int failures = 0;
    int n_jl = 0, n_jr = 0, n_jf = 0, n_adv = 0, n_multi = 0;
    int m_score = 0;

    always #5 clk = ~clk;

    jump_ctrl #(.LAND_TIMEOUT(24'd100), .SCORE_MAX(10'd999)) dut (
        .clk(clk), .rst_n(rst_n), .module_en(module_en),
        .btn_left(btn_left), .btn_right(btn_right),
        .block_side(block_side), .block_valid(block_valid), .landed(landed),
        .jump_left(jump_left), .jump_right(jump_right), .jump_fail(jump_fail),
        .block_advance(block_advance), .score(score),
        .game_over(game_over), .timeout_err(timeout_err)
    );

    always @(negedge clk) begin
        n_jl  += int'(jump_left);
        n_jr  += int'(jump_right);
        n_jf  += int'(jump_fail);
        n_adv += int'(block_advance);
        if (int'(jump_left) + int'(jump_right) + int'(jump_fail) + int'(block_advance) > 1)
            n_multi++;
    end

    // Expected command for a press: 1 = left, 2 = right, 3 = fail.
    function automatic int model_cmd(input bit right, input bit valid, input bit side);
        if (valid && (right == side)) return right ? 2 : 1;
        return 3;
    endfunction

    function automatic logic [2:0] cmd_bits(input int c);
        return (c == 1) ? 3'b001 : (c == 2) ? 3'b010 : 3'b100;
    endfunction

    function automatic int model_inc(input int s);
        return (s >= 999) ? 999 : s + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit right);
        if (right) btn_right = 1'b1; else btn_left = 1'b1;
        tick();
    endtask

    task automatic release_btns();
        btn_left = 1'b0;
        btn_right = 1'b0;
        tick();
    endtask

    task automatic pulse_landed();
        landed = 1'b1;
        tick();
        landed = 1'b0;
    endtask

    task automatic clear_game();
        module_en = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        landed = 1'b0;
        tick();
        module_en = 1'b1;
        tick();
        m_score = 0;
    endtask

    task automatic test_reset();
        int c0;
        rst_n = 1'b0; module_en = 1'b1; btn_left = 1'b1; btn_right = 1'b0;
        landed = 1'b0; block_valid = 1'b1; block_side = 1'b0;
        repeat (3) tick();
        checks++;
        if ({jump_left, jump_right, jump_fail, block_advance, game_over, timeout_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {jump_left, jump_right, jump_fail, block_advance, game_over, timeout_err});
        end
        checks++;
        if (score !== 10'd0) begin
            failures++;
            $display("FAIL reset_score got=%0d want=0", score);
        end
        c0 = n_jl + n_jr + n_jf;
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (n_jl + n_jr + n_jf - c0 != 0) begin
            failures++;
            $display("FAIL held_through_reset got=%0d cmds want=0", n_jl + n_jr + n_jf - c0);
        end
        release_btns();
        press(1'b0);
        checks++;
        if (jump_left !== 1'b1) begin
            failures++;
            $display("FAIL first_press_left got=%b want=1", jump_left);
        end
        release_btns();
        pulse_landed();
        m_score = model_inc(m_score);
        checks++;
        if (score !== 10'(m_score)) begin
            failures++;
            $display("FAIL first_land_score got=%0d want=%0d", score, m_score);
        end
    endtask

    task automatic test_correct_jump();
        int jr0, adv0;
        clear_game();
        block_valid = 1'b1; block_side = 1'b1;
        jr0 = n_jr; adv0 = n_adv;
        press(1'b1);
        checks++;
        if ({jump_fail, jump_right, jump_left} !== 3'b010) begin
            failures++;
            $display("FAIL correct_cmd got=%b want=010", {jump_fail, jump_right, jump_left});
        end
        release_btns();
        checks++;
        if (jump_right !== 1'b0) begin
            failures++;
            $display("FAIL correct_cmd_width got=%b want=0", jump_right);
        end
        repeat (8) tick();
        pulse_landed();
        checks++;
        if (block_advance !== 1'b1 || score !== 10'd1) begin
            failures++;
            $display("FAIL correct_land got adv=%b score=%0d want adv=1 score=1", block_advance, score);
        end
        tick();
        checks++;
        if (block_advance !== 1'b0 || n_adv - adv0 != 1 || n_jr - jr0 != 1) begin
            failures++;
            $display("FAIL correct_pulse_counts got adv=%0d jr=%0d want 1 1", n_adv - adv0, n_jr - jr0);
        end
        m_score = 1;
    endtask

    task automatic test_wrong_side();
        int c0;
        clear_game();
        block_valid = 1'b1; block_side = 1'b0;
        press(1'b1);
        checks++;
        if ({jump_fail, jump_right, jump_left} !== 3'b100) begin
            failures++;
            $display("FAIL wrong_side_cmd got=%b want=100", {jump_fail, jump_right, jump_left});
        end
        release_btns();
        repeat (3) tick();
        pulse_landed();
        checks++;
        if (game_over !== 1'b1 || timeout_err !== 1'b0 || score !== 10'd0) begin
            failures++;
            $display("FAIL wrong_side_over got go=%b te=%b score=%0d want 1 0 0", game_over, timeout_err, score);
        end
        c0 = n_jl + n_jr + n_jf + n_adv;
        for (int i = 0; i < 4; i++) begin
            press(1'($urandom_range(0, 1)));
            release_btns();
            pulse_landed();
        end
        tick();
        checks++;
        if (n_jl + n_jr + n_jf + n_adv - c0 != 0 || game_over !== 1'b1) begin
            failures++;
            $display("FAIL over_terminal got pulses=%0d go=%b want 0 1", n_jl + n_jr + n_jf + n_adv - c0, game_over);
        end
    endtask

    task automatic test_held_simul();
        int c0;
        clear_game();
        block_valid = 1'b1; block_side = 1'b1;
        c0 = n_jl + n_jr + n_jf;
        btn_left = 1'b1; btn_right = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (n_jl + n_jr + n_jf - c0 != 0) begin
            failures++;
            $display("FAIL simultaneous got=%0d cmds want=0", n_jl + n_jr + n_jf - c0);
        end
        release_btns();
        press(1'b1);
        checks++;
        if (jump_right !== 1'b1) begin
            failures++;
            $display("FAIL held_first_press got=%b want=1", jump_right);
        end
        release_btns();
        c0 = n_jl + n_jr + n_jf;
        press(1'b0);
        release_btns();
        press(1'b1);
        release_btns();
        checks++;
        if (n_jl + n_jr + n_jf - c0 != 0) begin
            failures++;
            $display("FAIL press_in_wait got=%0d cmds want=0", n_jl + n_jr + n_jf - c0);
        end
        pulse_landed();
        checks++;
        if (block_advance !== 1'b1 || score !== 10'd1) begin
            failures++;
            $display("FAIL held_land got adv=%b score=%0d want 1 1", block_advance, score);
        end
        press(1'b1);
        checks++;
        if (jump_right !== 1'b1) begin
            failures++;
            $display("FAIL repress_after_land got=%b want=1", jump_right);
        end
        release_btns();
        pulse_landed();
        m_score = 2;
    endtask

    task automatic test_timeout();
        int k;
        clear_game();
        block_valid = 1'b1; block_side = 1'b0;
        press(1'b0);
        checks++;
        if (jump_left !== 1'b1) begin
            failures++;
            $display("FAIL timeout_cmd got=%b want=1", jump_left);
        end
        btn_left = 1'b0;
        k = 0;
        while (game_over !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (k != 100) begin
            failures++;
            $display("FAIL timeout_latency got=%0d cycles want=100", k);
        end
        checks++;
        if (timeout_err !== 1'b1 || score !== 10'd0) begin
            failures++;
            $display("FAIL timeout_flags got te=%b score=%0d want 1 0", timeout_err, score);
        end
    endtask

    task automatic test_clear_mid_jump();
        int c0, a0;
        clear_game();
        block_valid = 1'b1; block_side = 1'b1;
        press(1'b1); release_btns(); pulse_landed();
        press(1'b1); release_btns();
        repeat (2) tick();
        a0 = n_adv;
        btn_right = 1'b1; module_en = 1'b0; landed = 1'b1;
        tick();
        checks++;
        if ({jump_left, jump_right, jump_fail, block_advance, game_over, timeout_err} !== 6'b0 || score !== 10'd0) begin
            failures++;
            $display("FAIL clear_outputs got flags=%b score=%0d want 0 0",
                     {jump_left, jump_right, jump_fail, block_advance, game_over, timeout_err}, score);
        end
        landed = 1'b0; module_en = 1'b1;
        c0 = n_jl + n_jr + n_jf;
        repeat (3) tick();
        pulse_landed();
        tick();
        checks++;
        if (n_jl + n_jr + n_jf - c0 != 0 || n_adv - a0 != 0) begin
            failures++;
            $display("FAIL clear_quiet got cmds=%0d adv=%0d want 0 0", n_jl + n_jr + n_jf - c0, n_adv - a0);
        end
        release_btns();
        press(1'b1);
        checks++;
        if (jump_right !== 1'b1) begin
            failures++;
            $display("FAIL clear_fresh_press got=%b want=1", jump_right);
        end
        release_btns();
        pulse_landed();
        m_score = 1;
    endtask

    task automatic test_random();
        bit r, v, s;
        int exp, gap;
        clear_game();
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 7) != 0);
            s = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 5) != 0) ? s : 1'($urandom_range(0, 1));
            block_valid = v; block_side = s;
            exp = model_cmd(r, v, s);
            press(r);
            checks++;
            if ({jump_fail, jump_right, jump_left} !== cmd_bits(exp)) begin
                failures++;
                $display("FAIL random_cmd[%0d] got=%b want=%b", i, {jump_fail, jump_right, jump_left}, cmd_bits(exp));
            end
            release_btns();
            gap = $urandom_range(0, 6);
            repeat (gap) tick();
            pulse_landed();
            if (exp != 3) begin
                m_score = model_inc(m_score);
                checks++;
                if (block_advance !== 1'b1 || score !== 10'(m_score)) begin
                    failures++;
                    $display("FAIL random_land[%0d] got adv=%b score=%0d want 1 %0d", i, block_advance, score, m_score);
                end
            end else begin
                checks++;
                if (game_over !== 1'b1 || timeout_err !== 1'b0 || score !== 10'(m_score)) begin
                    failures++;
                    $display("FAIL random_fall[%0d] got go=%b te=%b score=%0d want 1 0 %0d",
                             i, game_over, timeout_err, score, m_score);
                end
                clear_game();
            end
        end
    endtask

    task automatic test_saturation();
        bit s;
        int a0;
        clear_game();
        block_valid = 1'b1;
        a0 = n_adv;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            block_side = s;
            press(s);
            release_btns();
            repeat ($urandom_range(0, 2)) tick();
            pulse_landed();
            m_score = model_inc(m_score);
            checks++;
            if (block_advance !== 1'b1 || score !== 10'(m_score)) begin
                failures++;
                $display("FAIL sat_iter[%0d] got adv=%b score=%0d want 1 %0d", i, block_advance, score, m_score);
            end
        end
        tick();
        checks++;
        if (score !== 10'd999 || n_adv - a0 != 1000) begin
            failures++;
            $display("FAIL sat_final got score=%0d adv=%0d want 999 1000", score, n_adv - a0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_multi != 0) begin
            failures++;
            $display("FAIL pulse_exclusive got=%0d overlapping cycles want=0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_correct_jump();
        test_wrong_side();
        test_held_simul();
        test_timeout();
        test_clear_mid_jump();
        test_random();
        test_saturation();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Game-logic initiator for the character's jump command interface. Watches debounced left/right buttons, compares each press against the side of the next block, and issues a one-cycle `jump_left`, `jump_right` or `jump_fail` command. It then waits for the character's `landed` acknowledgement before accepting the next press, keeping the score and raising `game_over` after a failed jump. It sits between the input/debounce logic and the block generator on one side, and the character block on the other, in the 40 MHz game clock domain.

## Interface
Parameters:
- `LAND_TIMEOUT`, default 24'd16_000_000: cycles to wait for `landed` after any command before forcing game over.
- `SCORE_MAX`, default 10'd999: score saturation value.

Ports:
- `clk`  in  1  40 MHz game clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `module_en`  in  1  game active; low acts as a synchronous clear identical to reset.
- `btn_left`  in  1  debounced left button level.
- `btn_right`  in  1  debounced right button level.
- `block_side`  in  1  side of the next block: 0 = left, 1 = right.
- `block_valid`  in  1  `block_side` is meaningful.
- `landed`  in  1  one-cycle pulse from the character: the jump or fall is complete.
- `jump_left`  out  1  one-cycle command pulse.
- `jump_right`  out  1  one-cycle command pulse.
- `jump_fail`  out  1  one-cycle command pulse.
- `block_advance`  out  1  one-cycle pulse requesting the next block.
- `score`  out  10  successful jumps, saturating.
- `game_over`  out  1  level; high from game end until clear.
- `timeout_err`  out  1  level; high if game over was caused by the timeout.

## Operation
- All outputs are registered. Reset or `module_en == 0` sets every output to 0, `state = S_READY`, the timer to 0, and both button-history registers to 1. The history reset to 1 means a button held through reset needs a release before it counts.
- Edge detection:
  - `rise_l = btn_left & ~prev_l`; `rise_r = btn_right & ~prev_r`.
  - History registers update every cycle in every state.
- States:
  - **S_READY**
    - Exactly one of `rise_l`/`rise_r` is set: a "press".
    - Press with `block_valid` and direction == `block_side` (left = 0) → pulse `jump_left`/`jump_right`, clear the timer, go to S_WAIT.
    - Press with `!block_valid` or the wrong side → pulse `jump_fail`, clear the timer, go to S_FALL.
    - Both rises in the same cycle → ignored, stay in S_READY.
    - `landed` in this state is ignored.
  - **S_WAIT**
    - `landed` → `score <= (score == SCORE_MAX) ? score : score + 1`, pulse `block_advance`, go to S_READY.
    - Timer reaches `LAND_TIMEOUT - 1` without `landed` → `game_over = 1`, `timeout_err = 1`, go to S_OVER.
    - Button edges are ignored.
  - **S_FALL**
    - `landed` → `game_over = 1`, go to S_OVER.
    - Timeout behaves as in S_WAIT.
  - **S_OVER**: terminal. All inputs are ignored. The only exit is reset or `module_en` low.
- At most one of `jump_left`, `jump_right`, `jump_fail`, `block_advance` is high in any cycle.
- The timer is 24 bits and increments only in S_WAIT and S_FALL; it never wraps.
- When `landed` and the timeout coincide, `landed` wins.

## Timing
- Button rise visible on the inputs at edge N (`btn` = 1, `prev` = 0) → command pulse high during cycle N+1, exactly 1 cycle wide.
- `landed` sampled at edge M → `score` updated and `block_advance` high in cycle M+1. S_READY is active from M+1, so a press sampled at M+1 issues its command at M+2.
- `game_over` rises in the cycle after the terminating `landed` or timeout edge.
- `module_en` falling mid-jump → all outputs are 0 on the next cycle; no `block_advance` is issued.

## Test plan
- **Correct jump:** `block_valid` = 1, `block_side` = 1, pulse `btn_right` 0→1; then `landed` 10 cycles later → `jump_right` high for exactly 1 cycle, `score` 0→1, one `block_advance` pulse, back in S_READY.
- **Wrong side:** `block_side` = 0, press right → single `jump_fail` pulse. `landed` → `game_over` = 1 and `timeout_err` = 0. Further presses produce no pulses.
- **Held and simultaneous presses:** button held through reset release → no command. Both buttons rise in the same cycle → no command. Press during S_WAIT → ignored; a re-press after `landed` → command.
- **Timeout:** `LAND_TIMEOUT` = 100, issue a correct jump, never assert `landed` → `game_over` = 1 and `timeout_err` = 1 exactly 100 cycles after the command; `score` unchanged.
- **Saturation:** 1000 correct jump/`landed` cycles with `SCORE_MAX` = 999 → `score` stays at 999 and `block_advance` still pulses each time.
- **Clear mid-jump:** `module_en` low during S_WAIT, then high → `score` = 0, `game_over` = 0, S_READY, and no command until a fresh press.
